// File: rtl/opcode_seq_pkg.sv
// rtl/opcode_seq_pkg.sv - shared types, class constants and helpers for the opcode fetch sequencer
//
// Purpose : sequencer state encoding, opcode class codes, class->operand
//           count mapping and the default inter-byte idle limit.
// Ports   : none (package).
package opcode_seq_pkg;

  typedef enum logic [1:0] {
    ST_OPCODE = 2'd0,
    ST_ARGS   = 2'd1,
    ST_EMIT   = 2'd2
  } state_t;

  localparam logic [2:0] CLS_ILLEGAL = 3'd0;
  localparam logic [2:0] CLS_4       = 3'd4;
  localparam logic [2:0] CLS_5       = 3'd5;
  localparam logic [2:0] CLS_6       = 3'd6;
  localparam logic [2:0] CLS_7       = 3'd7;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

  // Operand bytes that follow an opcode of the given class.
  function automatic logic [1:0] class_nargs(input logic [2:0] cls);
    case (cls)
      CLS_5:   return 2'd1;
      CLS_6:   return 2'd2;
      CLS_7:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/opcode_class_decode.sv
// rtl/opcode_class_decode.sv - combinational opcode byte to class decoder
//
// Purpose : map an opcode byte onto its instruction class; unknown bytes
//           decode to CLS_ILLEGAL.
// Ports   : opcode_i [7:0] in  - candidate opcode byte
//           cls_o    [2:0] out - decoded class (0 = illegal, else 4..7)
module opcode_class_decode
  import opcode_seq_pkg::*;
(
  input  logic [7:0] opcode_i,
  output logic [2:0] cls_o
);

  always_comb begin
    cls_o = CLS_ILLEGAL;
    case (opcode_i)
      8'hB0:                                    cls_o = CLS_4;
      8'hB4:                                    cls_o = CLS_5;
      8'h98, 8'h99, 8'h9A, 8'h9B, 8'h9E, 8'h9F: cls_o = CLS_7;
      8'h90, 8'h91:                             cls_o = CLS_6;
      8'hB2:                                    cls_o = CLS_5;
      8'hBC:                                    cls_o = CLS_4;
      default:                                  cls_o = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/opcode_fetch_seq.sv
// rtl/opcode_fetch_seq.sv - byte-stream instruction sequencer in front of the opcode class decoder
//
// Purpose : accept one byte per in_valid/in_ready handshake, classify the
//           opcode byte, gather its operand bytes and present the assembled
//           instruction on out_valid/out_ready. Illegal opcodes are dropped,
//           pulsed on err_illegal and counted (saturating) in illegal_cnt.
// Option  : OPCODE_FETCH_SEQ_TIMEOUT_EN - when defined, a partial instruction
//           idle for TIMEOUT_CYCLES ARGS cycles is aborted with err_timeout;
//           otherwise ARGS waits forever and err_timeout is tied 0.
// Ports   : clk, reset (async, active-high)
//           in_valid, in_data[7:0], in_ready      - byte input stream
//           out_valid, out_ready                  - instruction handshake
//           out_opcode[7:0], out_class[2:0], out_nargs[1:0], out_args[23:0]
//           err_illegal, err_timeout              - registered 1-cycle pulses
//           illegal_cnt[7:0]                      - saturating illegal count
module opcode_fetch_seq
  import opcode_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_opcode,
  output logic [2:0]  out_class,
  output logic [1:0]  out_nargs,
  output logic [23:0] out_args,
  output logic        err_illegal,
  output logic        err_timeout,
  output logic [7:0]  illegal_cnt
);

  state_t      state_q, state_d;
  logic [7:0]  opcode_q;
  logic [2:0]  class_q;
  logic [1:0]  nargs_q;
  logic [23:0] args_q;
  logic [1:0]  idx_q;
  logic        err_illegal_q;
  logic [7:0]  illegal_cnt_q;

  logic [2:0]  dec_cls;
  logic [1:0]  dec_nargs;
  logic        accept;
  logic        last_arg;
  logic        timeout_abort;

  opcode_class_decode u_decode (
    .opcode_i (in_data),
    .cls_o    (dec_cls)
  );

  assign dec_nargs = class_nargs(dec_cls);
  assign accept    = in_valid & in_ready;
  // idx never exceeds nargs-1 while in ARGS, so the 2-bit add cannot wrap.
  assign last_arg  = (idx_q + 2'd1) == nargs_q;

`ifdef OPCODE_FETCH_SEQ_TIMEOUT_EN
  localparam logic [16:0] TMO_LIMIT = 17'(TIMEOUT_CYCLES);

  logic [15:0] idle_q;
  logic        err_timeout_q;

  // Abort on the idle ARGS cycle that would bring the counter to the limit;
  // an accepted byte in that same cycle takes priority.
  assign timeout_abort = (state_q == ST_ARGS) && !accept &&
                         (({1'b0, idle_q} + 17'd1) == TMO_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_q        <= 16'd0;
      err_timeout_q <= 1'b0;
    end else begin
      err_timeout_q <= timeout_abort;
      if (state_q != ST_ARGS || accept || timeout_abort) begin
        idle_q <= 16'd0;
      end else begin
        idle_q <= idle_q + 16'd1;
      end
    end
  end

  assign err_timeout = err_timeout_q;
`else
  assign timeout_abort = 1'b0;
  assign err_timeout   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_OPCODE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OPCODE: begin
        if (accept && dec_cls != CLS_ILLEGAL) begin
          state_d = (dec_nargs == 2'd0) ? ST_EMIT : ST_ARGS;
        end
      end
      ST_ARGS: begin
        if (accept && last_arg) begin
          state_d = ST_EMIT;
        end else if (timeout_abort) begin
          state_d = ST_OPCODE;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          state_d = ST_OPCODE;
        end
      end
      default: state_d = ST_OPCODE;
    endcase
  end

  // State-decoded outputs: no byte is taken while an instruction is on offer.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_OPCODE: in_ready  = 1'b1;
      ST_ARGS:   in_ready  = 1'b1;
      ST_EMIT:   out_valid = 1'b1;
      default:   in_ready  = 1'b0;
    endcase
  end

  // Instruction datapath and illegal-opcode bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode_q      <= 8'd0;
      class_q       <= CLS_ILLEGAL;
      nargs_q       <= 2'd0;
      args_q        <= 24'd0;
      idx_q         <= 2'd0;
      err_illegal_q <= 1'b0;
      illegal_cnt_q <= 8'd0;
    end else begin
      err_illegal_q <= 1'b0;
      if (accept && state_q == ST_OPCODE) begin
        if (dec_cls == CLS_ILLEGAL) begin
          err_illegal_q <= 1'b1;
          if (illegal_cnt_q != 8'hFF) begin
            illegal_cnt_q <= illegal_cnt_q + 8'd1;
          end
        end else begin
          opcode_q <= in_data;
          class_q  <= dec_cls;
          nargs_q  <= dec_nargs;
          args_q   <= 24'd0;
          idx_q    <= 2'd0;
        end
      end else if (accept && state_q == ST_ARGS) begin
        case (idx_q)
          2'd0:    args_q[7:0]   <= in_data;
          2'd1:    args_q[15:8]  <= in_data;
          default: args_q[23:16] <= in_data;
        endcase
        idx_q <= idx_q + 2'd1;
      end else if (timeout_abort) begin
        opcode_q <= 8'd0;
        class_q  <= CLS_ILLEGAL;
        nargs_q  <= 2'd0;
        args_q   <= 24'd0;
        idx_q    <= 2'd0;
      end
    end
  end

  assign out_opcode  = opcode_q;
  assign out_class   = class_q;
  assign out_nargs   = nargs_q;
  assign out_args    = args_q;
  assign err_illegal = err_illegal_q;
  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_opcode_fetch_seq.sv
// tb/tb_opcode_fetch_seq.sv - directed self-checking bench for opcode_fetch_seq
module tb_opcode_fetch_seq;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_opcode;
  logic [2:0]  out_class;
  logic [1:0]  out_nargs;
  logic [23:0] out_args;
  logic        err_illegal;
  logic        err_timeout;
  logic [7:0]  illegal_cnt;

  int n_cmp = 0;
  int n_err = 0;

  opcode_fetch_seq #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_opcode  (out_opcode),
    .out_class   (out_class),
    .out_nargs   (out_nargs),
    .out_args    (out_args),
    .err_illegal (err_illegal),
    .err_timeout (err_timeout),
    .illegal_cnt (illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Table of opcodes around the class boundaries with hand-derived classes.
  logic [7:0] tbl_op  [16] = '{8'h98, 8'h9B, 8'h9C, 8'h9D, 8'h9E, 8'h9F, 8'h90, 8'h91,
                               8'h92, 8'hB2, 8'hB3, 8'hBC, 8'hB0, 8'hB4, 8'h8F, 8'hB5};
  logic [2:0] tbl_cls [16] = '{3'd7,  3'd7,  3'd0,  3'd0,  3'd7,  3'd7,  3'd6,  3'd6,
                               3'd0,  3'd5,  3'd0,  3'd4,  3'd4,  3'd5,  3'd0,  3'd0};

  logic [7:0]  stream [$];
  logic [31:0] exp_q  [$];
  logic [31:0] head;
  int          pulses;
  int          seen_valid;
  int          ptr;
  int          done_cnt;
  int          k;
  logic [23:0] eargs;
  logic        acc_in;
  logic        acc_out;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    tick();
    tick();

    // Reset values
    chk("rst_in_ready",   in_ready,    1);
    chk("rst_out_valid",  out_valid,   0);
    chk("rst_opcode",     out_opcode,  0);
    chk("rst_class",      out_class,   0);
    chk("rst_nargs",      out_nargs,   0);
    chk("rst_args",       out_args,    0);
    chk("rst_err_ill",    err_illegal, 0);
    chk("rst_err_tmo",    err_timeout, 0);
    chk("rst_ill_cnt",    illegal_cnt, 0);
    reset = 1'b0;
    tick();

    // 0xB0: zero-operand instruction, valid for one cycle
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'hB0;
    tick();
    in_valid = 1'b0;
    chk("b0_valid",  out_valid,  1);
    chk("b0_ready",  in_ready,   0);
    chk("b0_opcode", out_opcode, 8'hB0);
    chk("b0_class",  out_class,  4);
    chk("b0_nargs",  out_nargs,  0);
    chk("b0_args",   out_args,   0);
    tick();
    chk("b0_drop",   out_valid,  0);
    chk("b0_ready2", in_ready,   1);

    // 0x9A 11 22 33 back to back, then back-pressure for 5 cycles
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h9A; tick();
    chk("9a_args_state", in_ready, 1);
    chk("9a_no_valid",   out_valid, 0);
    in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    in_data = 8'h33; tick();
    in_data = 8'h44;
    for (int i = 0; i < 5; i++) begin
      chk("9a_hold_valid", out_valid, 1);
      chk("9a_hold_ready", in_ready,  0);
      chk("9a_hold_args",  out_args,  24'h332211);
      chk("9a_hold_class", out_class, 7);
      chk("9a_hold_nargs", out_nargs, 3);
      chk("9a_hold_op",    out_opcode, 8'h9A);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("9a_release", out_valid, 0);
    chk("9a_ready",   in_ready,  1);

    // 300 illegal bytes
    out_ready = 1'b0;
    pulses = 0; seen_valid = 0;
    in_valid = 1'b1; in_data = 8'h00;
    tick();
    chk("ill_first_cnt", illegal_cnt, 1);
    if (err_illegal) pulses++;
    for (int i = 1; i < 300; i++) begin
      tick();
      if (err_illegal) pulses++;
      if (out_valid) seen_valid++;
    end
    in_valid = 1'b0;
    chk("ill_pulses",  pulses,      300);
    chk("ill_cnt_sat", illegal_cnt, 255);
    chk("ill_novalid", seen_valid,  0);
    tick();
    chk("ill_pulse_end", err_illegal, 0);
    in_valid = 1'b1; in_data = 8'hFF; tick();
    in_valid = 1'b0;
    chk("ill_single_pulse", err_illegal, 1);
    chk("ill_cnt_hold",     illegal_cnt, 255);
    tick();
    chk("ill_single_end",   err_illegal, 0);

    // Reset in the middle of 0x91 0xAA
    in_valid = 1'b1; in_data = 8'h91; tick();
    in_data = 8'hAA; tick();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_ready",  in_ready,    1);
    chk("mid_rst_valid",  out_valid,   0);
    chk("mid_rst_opcode", out_opcode,  0);
    chk("mid_rst_class",  out_class,   0);
    chk("mid_rst_nargs",  out_nargs,   0);
    chk("mid_rst_args",   out_args,    0);
    chk("mid_rst_cnt",    illegal_cnt, 0);
    chk("mid_rst_err",    err_illegal, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_err_ill", err_illegal, 0);
    chk("post_rst_err_tmo", err_timeout, 0);
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'hB4; tick();
    chk("b4_wait", out_valid, 0);
    in_data = 8'h55; tick();
    in_valid = 1'b0;
    chk("b4_valid", out_valid, 1);
    chk("b4_class", out_class, 5);
    chk("b4_nargs", out_nargs, 1);
    chk("b4_args",  out_args,  24'h000055);
    tick();
    chk("b4_done",  out_valid, 0);

    // Class table sweep, out_ready held high
    for (int t = 0; t < 16; t++) begin
      in_valid = 1'b1; in_data = tbl_op[t];
      tick();
      if (tbl_cls[t] == 3'd0) begin
        in_valid = 1'b0;
        chk("tbl_illegal_pulse", err_illegal, 1);
        chk("tbl_illegal_nov",   out_valid,   0);
      end else begin
        k = (tbl_cls[t] == 3'd4) ? 0 : int'(tbl_cls[t]) - 4;
        eargs = 24'd0;
        for (int a = 0; a < k; a++) begin
          in_data = 8'hA0 + 8'(a);
          eargs[8*a +: 8] = 8'hA0 + 8'(a);
          tick();
        end
        in_valid = 1'b0;
        chk("tbl_valid", out_valid,  1);
        chk("tbl_op",    out_opcode, tbl_op[t]);
        chk("tbl_class", out_class,  tbl_cls[t]);
        chk("tbl_nargs", out_nargs,  k);
        chk("tbl_args",  out_args,   eargs);
        tick();
        chk("tbl_drain", out_valid, 0);
      end
    end

`ifdef OPCODE_FETCH_SEQ_TIMEOUT_EN
    // Timeout after 4 idle ARGS cycles
    in_valid = 1'b1; in_data = 8'hB2; tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("tmo_no_pulse", err_timeout, 0);
    end
    tick();
    chk("tmo_pulse",  err_timeout, 1);
    chk("tmo_ready",  in_ready,    1);
    chk("tmo_novalid", out_valid,  0);
    tick();
    chk("tmo_pulse_end", err_timeout, 0);
    in_valid = 1'b1; in_data = 8'hB0; tick();
    in_valid = 1'b0;
    chk("tmo_opcode_state", out_valid, 1);
    chk("tmo_opcode_cls",   out_class, 4);
    tick();
    // Byte on idle cycle 4 wins over the timeout
    in_valid = 1'b1; in_data = 8'hB2; tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    in_valid = 1'b1; in_data = 8'h77; tick();
    in_valid = 1'b0;
    chk("tmo_race_valid", out_valid,   1);
    chk("tmo_race_err",   err_timeout, 0);
    chk("tmo_race_args",  out_args,    24'h000077);
    tick();
    chk("tmo_race_err2",  err_timeout, 0);
`else
    // Without the timeout, ARGS waits indefinitely
    in_valid = 1'b1; in_data = 8'hB2; tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("wait_ready", in_ready,    1);
    chk("wait_noval", out_valid,   0);
    chk("wait_notmo", err_timeout, 0);
    in_valid = 1'b1; in_data = 8'h66; tick();
    in_valid = 1'b0;
    chk("wait_valid", out_valid, 1);
    chk("wait_args",  out_args,  24'h000066);
    tick();
`endif

    // Random handshake toggling: alternate 0x9E+3 args and 0xBC
    for (int n = 0; n < 12; n++) begin
      if (n % 2 == 0) begin
        stream.push_back(8'h9E);
        stream.push_back(8'(n * 3 + 1));
        stream.push_back(8'(n * 3 + 2));
        stream.push_back(8'(n * 3 + 3));
        exp_q.push_back({8'h9E, 8'(n * 3 + 3), 8'(n * 3 + 2), 8'(n * 3 + 1)});
      end else begin
        stream.push_back(8'hBC);
        exp_q.push_back({8'hBC, 24'h000000});
      end
    end
    ptr = 0; done_cnt = 0;
    for (int c = 0; c < 2000 && done_cnt < 12; c++) begin
      in_valid  = (ptr < stream.size()) && ($urandom_range(0, 1) == 1);
      in_data   = (ptr < stream.size()) ? stream[ptr] : 8'h00;
      out_ready = ($urandom_range(0, 1) == 1);
      #4;
      acc_in  = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      if (acc_out) begin
        if (exp_q.size() == 0) begin
          chk("rnd_extra_output", 1, 0);
        end else begin
          head = exp_q.pop_front();
          chk("rnd_instr", {out_opcode, out_args}, head);
          chk("rnd_class", out_class, (head[31:24] == 8'h9E) ? 7 : 4);
        end
        done_cnt++;
      end
      if (acc_in) ptr++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("rnd_done_count", done_cnt, 12);
    chk("rnd_all_bytes",  ptr,      stream.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/opcode_fetch_seq.md
# opcode_fetch_seq

Byte-stream instruction sequencer that sits in front of the opcode class decoder. It accepts one byte per handshake and classifies the first byte of each instruction. It then collects the number of operand bytes that class requires and presents the assembled instruction on a valid/ready output port. Illegal opcodes are dropped, flagged and counted.

## Interface
- `TIMEOUT_CYCLES`, 255: idle cycles allowed between operand bytes before abort (only with timeout compiled in); range 1..65535.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  byte available.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  sequencer accepts byte this cycle.
- `out_valid`  out  1  assembled instruction valid.
- `out_ready`  in  1  consumer accepts instruction.
- `out_opcode`  out  8  opcode byte.
- `out_class`  out  3  decoded class (4..7).
- `out_nargs`  out  2  operand count (0..3).
- `out_args`  out  24  operands; first operand in [7:0], second in [15:8], third in [23:16]; unused bytes zero.
- `err_illegal`  out  1  one-cycle pulse: illegal opcode dropped.
- `err_timeout`  out  1  one-cycle pulse: partial instruction aborted (tied 0 without macro).
- `illegal_cnt`  out  8  saturating count of illegal opcodes.

## Operation
- Class table (first match wins):
  - 0xB0 → class 4, 0 args.
  - 0xB4 → class 5, 1 arg.
  - 0x98–0x9B and 0x9E–0x9F → class 7, 3 args.
  - 0x90–0x91 → class 6, 2 args.
  - 0xB2 → class 5, 1 arg.
  - 0xBC → class 4, 0 args.
  - Anything else → class 0, illegal.
- States:
  - OPCODE: `in_ready`=1. On accept:
    - Class 0: drop the byte, pulse `err_illegal`, increment `illegal_cnt` (holds at 255), stay in OPCODE.
    - 0 args: latch the opcode and go to EMIT.
    - Otherwise: latch opcode/class/nargs, clear the arg register and arg index, go to ARGS.
  - ARGS: `in_ready`=1. Each accept stores the byte at `out_args[8*idx +: 8]` and increments idx. Go to EMIT on the accept that makes idx == nargs.
  - EMIT: `in_ready`=0, `out_valid`=1, outputs stable. When `out_ready`=1, return to OPCODE.
- Bytes are never accepted while `out_valid`=1. No bypass path.

## Timing
- Reset values:
  - State OPCODE, `in_ready`=1.
  - `out_valid`=0; `out_opcode`, `out_class`, `out_nargs` and `out_args` all 0.
  - `err_illegal`=0, `err_timeout`=0, `illegal_cnt`=0.
- `out_valid` rises the cycle after the final byte of the instruction is accepted (1-cycle latency).
- Minimum instruction period is nargs+2 cycles: nargs+1 accept cycles plus 1 EMIT cycle, with `out_ready` held high.
- Both error pulses are registered: high the cycle after the causing event, for exactly one cycle.
- `out_ready` asserted while `out_valid`=0 has no effect.
- Reset asserted mid-instruction discards any partial instruction or pending output immediately; no error pulse is produced.

## Configuration
- `OPCODE_FETCH_SEQ_TIMEOUT_EN` defined:
  - A 16-bit idle counter runs in ARGS only.
  - It clears on entry to ARGS and on every accepted byte, and increments on every ARGS cycle with no accept.
  - When it reaches `TIMEOUT_CYCLES`: discard the partial instruction, pulse `err_timeout`, return to OPCODE.
  - If a byte is accepted in the same cycle the counter would reach `TIMEOUT_CYCLES`, the byte wins and no timeout occurs.
- Not defined: ARGS waits indefinitely, no counter is built, `err_timeout` is tied 0.

## Structure
- Shared package `opcode_seq_pkg` holds:
  - State enum (OPCODE, ARGS, EMIT).
  - Class constants `CLS_ILLEGAL`=0 and classes 4..7.
  - Class→nargs function.
  - `TIMEOUT_CYCLES` default.
- One combinational sub-module `opcode_class_decode`: 8-bit opcode in, 3-bit class out, implementing the table above. Instantiated once on `in_data`.

## Test plan
- Feed 0xB0 with `out_ready`=1 → `out_valid` for 1 cycle, class 4, nargs 0, args 0x000000.
- Feed 0x9A, 0x11, 0x22, 0x33 back to back → `out_args`=0x332211, class 7, nargs 3. Hold `out_ready`=0 for 5 cycles → outputs stable and `in_ready`=0 throughout.
- Feed 0x00 three hundred times → 300 `err_illegal` pulses, `illegal_cnt`=255, no `out_valid`.
- Feed 0x91, 0xAA, then assert reset mid-instruction → all outputs return to reset values. Then feed 0xB4, 0x55 → class 5, args 0x000055.
- With TIMEOUT_EN and `TIMEOUT_CYCLES`=4: feed 0xB2, then idle 4 cycles → one `err_timeout` pulse, state OPCODE. Repeat with a byte arriving on idle cycle 4 → instruction completes with no timeout.
- Alternate 0x9E+3 args and 0xBC while randomly toggling `in_valid`/`out_ready` → output sequence matches a reference queue with no drops or duplicates.
